// File: rtl/vx_local_mem_ctrl.sv
`default_nettype none
// =============================================================================
// vx_local_mem_ctrl: GPU/host arbiter for one single-port local SRAM with
// credit-managed response FIFOs. Option macro: VX_LMEM_HOST_PRIO_EN. Rev 1.0
// =============================================================================

module vx_local_mem_ctrl_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Credits bound occupancy; a push into a full FIFO means credit accounting broke.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(i_push && (r_count == c_CNT_W'(DEPTH))));
endmodule

module vx_local_mem_ctrl #(
  parameter int ADDR_W    = 26,
  parameter int DATA_W    = 512,
  parameter int BYTEEN_W  = DATA_W / 8,
  parameter int TAG_W     = 8,
  parameter int RD_LAT    = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_mem_req_valid,
  input  logic                i_mem_req_rw,
  input  logic [BYTEEN_W-1:0] i_mem_req_byteen,
  input  logic [ADDR_W-1:0]   i_mem_req_addr,
  input  logic [DATA_W-1:0]   i_mem_req_data,
  input  logic [TAG_W-1:0]    i_mem_req_tag,
  output logic                o_mem_req_ready,
  output logic                o_mem_rsp_valid,
  output logic [DATA_W-1:0]   o_mem_rsp_data,
  output logic [TAG_W-1:0]    o_mem_rsp_tag,
  input  logic                i_mem_rsp_ready,
  input  logic                i_h_req_valid,
  input  logic                i_h_req_rw,
  input  logic [BYTEEN_W-1:0] i_h_req_byteen,
  input  logic [ADDR_W-1:0]   i_h_req_addr,
  input  logic [DATA_W-1:0]   i_h_req_data,
  output logic                o_h_req_ready,
  output logic                o_h_rsp_valid,
  output logic [DATA_W-1:0]   o_h_rsp_data,
  input  logic                i_h_rsp_ready,
  output logic                o_sram_en,
  output logic                o_sram_we,
  output logic [BYTEEN_W-1:0] o_sram_byteen,
  output logic [ADDR_W-1:0]   o_sram_addr,
  output logic [DATA_W-1:0]   o_sram_wdata,
  input  logic [DATA_W-1:0]   i_sram_rdata,
  output logic                o_busy
);
  localparam int c_CNT_W = $clog2(RSP_DEPTH + 1);

  logic [c_CNT_W-1:0] r_g_cred;
  logic [c_CNT_W-1:0] r_h_cred;
  logic               w_g_elig;
  logic               w_h_elig;
  logic               w_grant_g;
  logic               w_grant_h;
  logic               w_g_rd_grant;
  logic               w_h_rd_grant;
  logic               w_g_pop;
  logic               w_h_pop;
  logic               w_g_push;
  logic               w_h_push;
  logic [RD_LAT-1:0]  r_pipe_vld;
  logic [RD_LAT-1:0]  r_pipe_src;
  logic [TAG_W-1:0]   r_pipe_tag [RD_LAT];

  // Gating with reset keeps every ready low while reset is held, even with valids up.
  assign w_g_elig = reset && i_mem_req_valid && (i_mem_req_rw || (r_g_cred != '0));
  assign w_h_elig = reset && i_h_req_valid && (i_h_req_rw || (r_h_cred != '0));

`ifdef VX_LMEM_HOST_PRIO_EN
  assign w_grant_h = w_h_elig;
  assign w_grant_g = w_g_elig && !w_h_elig;
`else
  logic r_last_host;

  assign w_grant_g = w_g_elig && (!w_h_elig || r_last_host);
  assign w_grant_h = w_h_elig && (!w_g_elig || !r_last_host);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_last_host <= 1'b1;
    else if (w_grant_g) r_last_host <= 1'b0;
    else if (w_grant_h) r_last_host <= 1'b1;
  end
`endif

  assign o_mem_req_ready = w_grant_g;
  assign o_h_req_ready   = w_grant_h;
  assign o_sram_en       = w_grant_g || w_grant_h;
  assign o_sram_we       = w_grant_h ? i_h_req_rw : (w_grant_g && i_mem_req_rw);
  assign o_sram_byteen   = w_grant_h ? i_h_req_byteen : i_mem_req_byteen;
  assign o_sram_addr     = w_grant_h ? i_h_req_addr   : i_mem_req_addr;
  assign o_sram_wdata    = w_grant_h ? i_h_req_data   : i_mem_req_data;

  assign w_g_rd_grant = w_grant_g && !i_mem_req_rw;
  assign w_h_rd_grant = w_grant_h && !i_h_req_rw;
  assign w_g_pop      = o_mem_rsp_valid && i_mem_rsp_ready;
  assign w_h_pop      = o_h_rsp_valid && i_h_rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_g_cred <= c_CNT_W'(RSP_DEPTH);
      r_h_cred <= c_CNT_W'(RSP_DEPTH);
    end else begin
      if (w_g_rd_grant && !w_g_pop)      r_g_cred <= r_g_cred - 1'b1;
      else if (!w_g_rd_grant && w_g_pop) r_g_cred <= r_g_cred + 1'b1;
      if (w_h_rd_grant && !w_h_pop)      r_h_cred <= r_h_cred - 1'b1;
      else if (!w_h_rd_grant && w_h_pop) r_h_cred <= r_h_cred + 1'b1;
    end
  end

  // Read tracker: the last stage lines up with the cycle sram_rdata is valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pipe_vld <= '0;
      r_pipe_src <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pipe_tag[i] <= '0;
    end else begin
      r_pipe_vld[0] <= w_g_rd_grant || w_h_rd_grant;
      r_pipe_src[0] <= w_grant_h;
      r_pipe_tag[0] <= i_mem_req_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_src[i] <= r_pipe_src[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  assign w_g_push = r_pipe_vld[RD_LAT-1] && !r_pipe_src[RD_LAT-1];
  assign w_h_push = r_pipe_vld[RD_LAT-1] &&  r_pipe_src[RD_LAT-1];

  vx_local_mem_ctrl_rsp_fifo #(
    .WIDTH (TAG_W + DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_gpu_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_g_push),
    .i_data  ({r_pipe_tag[RD_LAT-1], i_sram_rdata}),
    .i_pop   (w_g_pop),
    .o_valid (o_mem_rsp_valid),
    .o_data  ({o_mem_rsp_tag, o_mem_rsp_data})
  );

  vx_local_mem_ctrl_rsp_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_host_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_h_push),
    .i_data  (i_sram_rdata),
    .i_pop   (w_h_pop),
    .o_valid (o_h_rsp_valid),
    .o_data  (o_h_rsp_data)
  );

  assign o_busy = (|r_pipe_vld) || o_mem_rsp_valid || o_h_rsp_valid;
endmodule

`default_nettype wire
